// File: rtl/sgb_pkg.sv
// ============================================================================
//  Module      : sgb_pkg
//  Description : Shared constants for the SGB command packet receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sgb_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ARMED     = 3'd1;
  localparam logic [2:0] ST_BIT_WAIT  = 3'd2;
  localparam logic [2:0] ST_BIT_HELD  = 3'd3;
  localparam logic [2:0] ST_STOP_WAIT = 3'd4;
  localparam logic [2:0] ST_STOP_HELD = 3'd5;

  // {P15, P14}, active-low
  localparam logic [1:0] LVL_RST  = 2'b00;
  localparam logic [1:0] LVL_B0   = 2'b10;
  localparam logic [1:0] LVL_B1   = 2'b01;
  localparam logic [1:0] LVL_IDLE = 2'b11;

  localparam int PKT_BITS = 128;

  function automatic logic [2:0] eff_len(input logic [2:0] field);
    return (field == 3'd0) ? 3'd1 : field;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sgb_rx_level_decode.sv
// ============================================================================
//  Module      : sgb_rx_level_decode
//  Description : Qualifies joypad select-line levels with ce into events.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sgb_rx_level_decode
  import sgb_pkg::*;
(
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ce,
  input  logic [1:0] joy_p54,
  output logic       ev_rst,
  output logic       ev_b0,
  output logic       ev_b1,
  output logic       ev_rel,
  output logic       ev_change
);

  logic [1:0] r_prev;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_prev <= LVL_IDLE;
    end else if (ce) begin
      r_prev <= joy_p54;
    end
  end

  assign ev_rst    = ce && (joy_p54 == LVL_RST);
  assign ev_b0     = ce && (joy_p54 == LVL_B0);
  assign ev_b1     = ce && (joy_p54 == LVL_B1);
  assign ev_rel    = ce && (joy_p54 == LVL_IDLE);
  assign ev_change = ce && (joy_p54 != r_prev);

endmodule

`default_nettype wire

// File: rtl/sgb_cmd_rx.sv
// ============================================================================
//  Module      : sgb_cmd_rx
//  Description : SGB packet receiver on P14/P15; groups packets into commands.
//                Optional idle timeout enabled by macro SGB_RX_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sgb_cmd_rx
  import sgb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic         clk_sys,
  input  logic         reset,
  input  logic         ce,
  input  logic         sgb_en,
  input  logic [1:0]   joy_p54,
  output logic [127:0] pkt_data,
  output logic         pkt_valid,
  output logic [2:0]   pkt_index,
  output logic [4:0]   cmd_code,
  output logic [2:0]   cmd_len,
  output logic         cmd_done,
  output logic         rx_error
);

  logic w_ev_rst, w_ev_b0, w_ev_b1, w_ev_rel, w_ev_change;
  logic w_timeout;

  logic [2:0]          r_state, w_state_nxt;
  logic [6:0]          r_bit_cnt;
  logic                r_held_bit;
  logic [PKT_BITS-1:0] r_shift;
  logic [127:0]        r_pkt_data;
  logic [2:0]          r_pkt_index, r_cmd_len;
  logic [4:0]          r_cmd_code;
  logic                r_cmd_open, r_pkt_valid, r_cmd_done, r_rx_error;

  logic w_shift_en, w_cnt_clr, w_cnt_inc, w_accept, w_error, w_swap, w_last_bit;
  logic [2:0] w_len_eff;

  sgb_rx_level_decode u_decode (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .ce        (ce),
    .joy_p54   (joy_p54),
    .ev_rst    (w_ev_rst),
    .ev_b0     (w_ev_b0),
    .ev_b1     (w_ev_b1),
    .ev_rel    (w_ev_rel),
    .ev_change (w_ev_change)
  );

`ifdef SGB_RX_TIMEOUT_EN
  logic [16:0] r_to_cnt;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_to_cnt <= '0;
    end else if (ce) begin
      if (w_ev_change) r_to_cnt <= '0;
      else if (r_to_cnt != '1) r_to_cnt <= r_to_cnt + 17'd1;
    end
  end

  assign w_timeout = ce && !w_ev_change && (r_state != ST_IDLE) &&
                     (r_to_cnt >= 17'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused;
  assign w_unused  = w_ev_change ^ (TIMEOUT_CYCLES != 0);
  assign w_timeout = 1'b0;
`endif

  // A held bit level jumping straight to the opposite bit level
  assign w_swap     = (w_ev_b0 && r_held_bit) || (w_ev_b1 && !r_held_bit);
  assign w_last_bit = (r_bit_cnt == 7'(PKT_BITS - 1));
  assign w_len_eff  = eff_len(r_shift[2:0]);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!sgb_en || w_timeout) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:      if (w_ev_rst) w_state_nxt = ST_ARMED;
        ST_ARMED:     if (w_ev_rel) w_state_nxt = ST_BIT_WAIT;
        ST_BIT_WAIT: begin
          if (w_ev_b0 || w_ev_b1) w_state_nxt = ST_BIT_HELD;
          else if (w_ev_rst)      w_state_nxt = ST_ARMED;
        end
        ST_BIT_HELD: begin
          if (w_ev_rel)      w_state_nxt = w_last_bit ? ST_STOP_WAIT : ST_BIT_WAIT;
          else if (w_ev_rst) w_state_nxt = ST_ARMED;
          else if (w_swap)   w_state_nxt = ST_IDLE;
        end
        ST_STOP_WAIT: begin
          if (w_ev_b0)       w_state_nxt = ST_STOP_HELD;
          else if (w_ev_b1)  w_state_nxt = ST_IDLE;
          else if (w_ev_rst) w_state_nxt = ST_ARMED;
        end
        ST_STOP_HELD: begin
          if (w_ev_rel)      w_state_nxt = ST_IDLE;
          else if (w_ev_rst) w_state_nxt = ST_ARMED;
          else if (w_ev_b1)  w_state_nxt = ST_IDLE;
        end
        default:             w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_shift_en = 1'b0;
    w_cnt_clr  = 1'b0;
    w_cnt_inc  = 1'b0;
    w_accept   = 1'b0;
    w_error    = w_timeout && sgb_en;
    if (sgb_en && !w_timeout) begin
      case (r_state)
        ST_ARMED:     w_cnt_clr  = w_ev_rel;
        ST_BIT_WAIT: begin
          w_shift_en = w_ev_b0 || w_ev_b1;
          w_error    = w_ev_rst && (r_bit_cnt != 7'd0);
        end
        ST_BIT_HELD: begin
          w_cnt_inc  = w_ev_rel && !w_last_bit;
          w_error    = w_ev_rst || w_swap;
        end
        ST_STOP_WAIT: w_error    = w_ev_b1 || w_ev_rst;
        ST_STOP_HELD: begin
          w_accept   = w_ev_rel;
          w_error    = w_ev_rst || w_ev_b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_bit_cnt   <= '0;
      r_held_bit  <= 1'b0;
      r_shift     <= '0;
      r_pkt_data  <= '0;
      r_pkt_index <= '0;
      r_cmd_code  <= '0;
      r_cmd_len   <= '0;
      r_cmd_open  <= 1'b0;
      r_pkt_valid <= 1'b0;
      r_cmd_done  <= 1'b0;
      r_rx_error  <= 1'b0;
    end else begin
      r_pkt_valid <= 1'b0;
      r_cmd_done  <= 1'b0;
      r_rx_error  <= 1'b0;
      if (!sgb_en) r_cmd_open <= 1'b0;

      if (w_cnt_clr)      r_bit_cnt <= '0;
      else if (w_cnt_inc) r_bit_cnt <= r_bit_cnt + 7'd1;

      if (w_shift_en) begin
        r_shift[r_bit_cnt] <= w_ev_b1;
        r_held_bit         <= w_ev_b1;
      end

      if (w_error) begin
        r_rx_error <= 1'b1;
        if (w_timeout) r_cmd_open <= 1'b0;
      end

      if (w_accept) begin
        r_pkt_data  <= r_shift;
        r_pkt_valid <= 1'b1;
        if (!r_cmd_open) begin
          r_cmd_code  <= r_shift[7:3];
          r_cmd_len   <= w_len_eff;
          r_pkt_index <= 3'd0;
          if (w_len_eff == 3'd1) r_cmd_done <= 1'b1;
          else                   r_cmd_open <= 1'b1;
        end else begin
          r_pkt_index <= r_pkt_index + 3'd1;
          if ((r_pkt_index + 3'd1) == (r_cmd_len - 3'd1)) begin
            r_cmd_done <= 1'b1;
            r_cmd_open <= 1'b0;
          end
        end
      end
    end
  end

  assign pkt_data  = r_pkt_data;
  assign pkt_valid = r_pkt_valid;
  assign pkt_index = r_pkt_index;
  assign cmd_code  = r_cmd_code;
  assign cmd_len   = r_cmd_len;
  assign cmd_done  = r_cmd_done;
  assign rx_error  = r_rx_error;

endmodule

`default_nettype wire

// File: tb/tb_sgb_cmd_rx.sv
// ============================================================================
//  Module      : tb_sgb_cmd_rx
//  Description : Scoreboard bench for sgb_cmd_rx with a packet-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sgb_cmd_rx;

  logic         clk_sys = 1'b0;
  logic         reset   = 1'b1;
  logic         ce      = 1'b0;
  logic         sgb_en  = 1'b1;
  logic [1:0]   joy_p54 = 2'b11;
  logic [127:0] pkt_data;
  logic         pkt_valid;
  logic [2:0]   pkt_index;
  logic [4:0]   cmd_code;
  logic [2:0]   cmd_len;
  logic         cmd_done;
  logic         rx_error;

  sgb_cmd_rx #(.TIMEOUT_CYCLES(100)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .ce        (ce),
    .sgb_en    (sgb_en),
    .joy_p54   (joy_p54),
    .pkt_data  (pkt_data),
    .pkt_valid (pkt_valid),
    .pkt_index (pkt_index),
    .cmd_code  (cmd_code),
    .cmd_len   (cmd_len),
    .cmd_done  (cmd_done),
    .rx_error  (rx_error)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    bit           is_err;
    logic [127:0] data;
    logic [2:0]   idx;
    logic [4:0]   code;
    logic [2:0]   len;
    logic         done;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Packet-level reference state
  bit           m_open = 0;
  logic [127:0] m_data = '0;
  logic [2:0]   m_idx  = '0;
  logic [4:0]   m_code = '0;
  logic [2:0]   m_len  = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void expect_err();
    exp_t e;
    e.is_err = 1; e.data = m_data; e.idx = m_idx;
    e.code = m_code; e.len = m_len; e.done = 0;
    q.push_back(e);
  endfunction

  function automatic void expect_pkt(input logic [127:0] p);
    exp_t e;
    int   len;
    if (!m_open) begin
      m_code = p[7:3];
      len    = (p[2:0] == 0) ? 1 : int'(p[2:0]);
      m_len  = 3'(len);
      m_idx  = 0;
    end else begin
      m_idx = m_idx + 1;
    end
    m_data = p;
    e.is_err = 0; e.data = p; e.idx = m_idx; e.code = m_code; e.len = m_len;
    e.done   = (int'(m_idx) == int'(m_len) - 1);
    m_open   = !e.done;
    q.push_back(e);
  endfunction

  // Drive a level for n ce-qualified clock edges, with ce randomly gapped
  task automatic hold(input logic [1:0] lvl, input int n);
    int k = 0;
    joy_p54 = lvl;
    while (k < n) begin
      ce = ($urandom_range(0, 3) != 0);
      @(posedge clk_sys);
      #1;
      if (ce) k++;
    end
  endtask

  task automatic start_pkt();
    hold(2'b00, $urandom_range(1, 3));
    hold(2'b11, $urandom_range(1, 3));
  endtask

  task automatic send_bits(input logic [127:0] p, input int from, input int to);
    for (int i = from; i <= to; i++) begin
      hold(p[i] ? 2'b01 : 2'b10, $urandom_range(1, 3));
      hold(2'b11, $urandom_range(1, 3));
    end
  endtask

  task automatic send_stop(input bit stop_one);
    hold(stop_one ? 2'b01 : 2'b10, $urandom_range(1, 3));
    hold(2'b11, $urandom_range(1, 3));
  endtask

  task automatic send_pkt(input logic [127:0] p, input bit stop_one);
    if (stop_one) expect_err();
    else          expect_pkt(p);
    start_pkt();
    send_bits(p, 0, 127);
    send_stop(stop_one);
  endtask

  function automatic logic [127:0] rand_pkt(input logic [7:0] b0);
    logic [127:0] p;
    p = {$urandom, $urandom, $urandom, $urandom};
    p[7:0] = b0;
    return p;
  endfunction

  always @(negedge clk_sys) begin
    if (!reset && (pkt_valid || rx_error || cmd_done)) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: got valid=%0b err=%0b done=%0b expected none",
                 pkt_valid, rx_error, cmd_done);
      end else begin
        m_e = q.pop_front();
        check("strobe_kind", {126'd0, pkt_valid, rx_error}, m_e.is_err ? 128'd1 : 128'd2);
        check("cmd_done", {127'd0, cmd_done}, {127'd0, m_e.done});
        check("pkt_data", pkt_data, m_e.data);
        check("pkt_index", {125'd0, pkt_index}, {125'd0, m_e.idx});
        if (!m_e.is_err) begin
          check("cmd_code", {123'd0, cmd_code}, {123'd0, m_e.code});
          check("cmd_len", {125'd0, cmd_len}, {125'd0, m_e.len});
        end
      end
    end
  end

  initial begin
    logic [127:0] p;
    repeat (3) @(posedge clk_sys);
    #1;
    check("rst_pkt_data", pkt_data, '0);
    check("rst_pkt_index", {125'd0, pkt_index}, '0);
    check("rst_cmd_code", {123'd0, cmd_code}, '0);
    check("rst_cmd_len", {125'd0, cmd_len}, '0);
    check("rst_strobes", {125'd0, pkt_valid, cmd_done, rx_error}, '0);
    reset = 1'b0;
    hold(2'b11, 4);

    // Single-packet command, code 0x11 len 1
    p[7:0] = 8'h89;
    for (int n = 1; n < 16; n++) p[8*n +: 8] = 8'(n);
    send_pkt(p, 0);

    // Three-packet command, code 0x0A
    send_pkt(rand_pkt(8'h53), 0);
    send_pkt(rand_pkt($urandom), 0);
    send_pkt(rand_pkt($urandom), 0);

    // Bad stop bit
    send_pkt(rand_pkt(8'h89), 1);

    // Reset pulse after 40 bits, then a good packet
    p = rand_pkt(8'h89);
    start_pkt();
    send_bits(p, 0, 39);
    expect_err();
    send_pkt(rand_pkt(8'h61), 0);

    // Length field 0 means one packet
    send_pkt(rand_pkt(8'h48), 0);

    // Open a command, then drop sgb_en mid-packet
    send_pkt(rand_pkt(8'h52), 0);
    start_pkt();
    send_bits(rand_pkt(8'h00), 0, 20);
    sgb_en = 1'b0;
    m_open = 0;
    hold(2'b00, 3);
    hold(2'b10, 2);
    hold(2'b11, 3);
    sgb_en = 1'b1;
    hold(2'b11, 2);
    send_pkt(rand_pkt(8'h89), 0);

    // Long idle after 5 bits
    p = rand_pkt(8'h89);
    start_pkt();
    send_bits(p, 0, 4);
`ifdef SGB_RX_TIMEOUT_EN
    expect_err();
    m_open = 0;
    hold(2'b11, 110);
    send_pkt(p, 0);
`else
    expect_pkt(p);
    hold(2'b11, 110);
    send_bits(p, 5, 127);
    send_stop(0);
`endif

    // Randomised traffic
    for (int t = 0; t < 14; t++) begin
      p = rand_pkt($urandom);
      if ($urandom_range(0, 6) == 0) begin
        send_pkt(p, 1);
      end else if ($urandom_range(0, 7) == 0) begin
        start_pkt();
        send_bits(p, 0, $urandom_range(1, 120));
        expect_err();
        send_pkt(rand_pkt($urandom), 0);
      end else begin
        send_pkt(p, 0);
      end
    end

    hold(2'b11, 20);
    check("queue_drained", 128'(q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
